spi_cmd_ctrl: RTL and testbench
===============================

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8, meaning the LED register-file depth.
REQ-002 The block SHALL have parameter BRI_BITS, default 7, meaning the brightness width per LED (payload[6:0]).
REQ-003 sysclk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rx_dv  in  1  one-cycle strobe: i_cmd/i_addr/i_payload valid.
REQ-006 i_cmd  in  CMD_BITS(2)  decoded command.
REQ-007 i_addr  in  ADDR_BITS(6)  decoded address.
REQ-008 i_payload  in  PAYLOAD_BITS(8)  decoded payload.
REQ-009 loc_req  in  1  local-writer request, held until granted.
REQ-010 loc_addr  in  ADDR_BITS; loc_bri  in  BRI_BITS  local write target and value.
REQ-011 loc_gnt  out  1  one-cycle grant; the local write commits in that cycle.
REQ-012 tx_vld  out  1  response frame valid to the SPI slave.
REQ-013 tx_rdy  in  1  SPI slave has taken the response frame.
REQ-014 o_tx_frame  out  MASTER_FRAME_WIDTH(16)  response frame {cmd,addr,payload}.
REQ-015 o_led_bri  out  NUM_LEDS*BRI_BITS  flattened brightness bus; LED k at bits [k*BRI_BITS +: BRI_BITS].
REQ-016 busy  out  1  FSM not in IDLE.
REQ-017 ovr_cnt  out  8  dropped-frame count, saturating at 255.
REQ-018 err_cnt  out  8  invalid-command/address count, saturating at 255.

Function
REQ-019 Commands SHALL be NOP=2'b00, LED_SET=2'b01, LED_READ=2'b10; 2'b11 is invalid.
REQ-020 FSM states SHALL be IDLE, EXEC, BCAST, RSP.
REQ-021 On rx_dv in IDLE, the frame SHALL be latched into a one-entry holding register and the FSM SHALL go to EXEC next cycle.
REQ-022 rx_dv while busy=1 SHALL drop the frame, leave the holding register unchanged and increment ovr_cnt.
REQ-023 EXEC, LED_SET, addr<NUM_LEDS: led[addr]<=payload[6:0]; visible on o_led_bri 1 cycle after EXEC; then IDLE.
REQ-024 EXEC, LED_SET, addr==6'h3F: go to BCAST and write payload[6:0] to LEDs 0..NUM_LEDS-1 one per cycle in index order; the cycle after the last write, return to IDLE.
REQ-025 EXEC, LED_READ, addr<NUM_LEDS: o_tx_frame<={2'b10,addr,1'b0,led[addr]}, tx_vld<=1, go to RSP.
REQ-026 EXEC, LED_READ, addr invalid: o_tx_frame<={2'b00,addr,8'hFF}, tx_vld<=1, err_cnt+1, go to RSP.
REQ-027 EXEC, LED_SET with invalid addr (not <NUM_LEDS, not 3F) or invalid cmd: no write, err_cnt+1, return to IDLE; NOP: return to IDLE, no effect.
REQ-028 In RSP, tx_vld and o_tx_frame SHALL hold until the cycle tx_vld&tx_rdy; next cycle tx_vld=0 and state=IDLE.
REQ-029 loc_gnt SHALL assert only in IDLE with rx_dv=0 and loc_req=1; SPI traffic has strict priority; loc_addr>=NUM_LEDS is granted with no write and no err_cnt change.
REQ-030 A loc_gnt write SHALL not change busy or the FSM state.
REQ-031 Counters SHALL saturate at 8'hFF, never wrap.
REQ-032 o_tx_frame SHALL be 16'h0000 whenever tx_vld=0.

Reset
REQ-033 rst=1 SHALL force: state IDLE, all LEDs 0, tx_vld 0, o_tx_frame 0, loc_gnt 0, ovr_cnt 0, err_cnt 0, holding register cleared.
REQ-034 rst during BCAST or RSP SHALL abort the operation; partial broadcast writes are cleared by the LED reset, and no response is delivered.

Structure
REQ-035 CMD codes, ADDR_BCAST (6'h3F), CMD/ADDR/PAYLOAD/MASTER_FRAME_WIDTH and NUM_LEDS SHALL come from the shared params.vh include.
REQ-036 The LED register file plus write-port mux SHALL be a sub-module led_regfile (one write port, flattened read bus).

Verification
REQ-037 SET addr 3, payload 8'h40 -> o_led_bri[27:21]=7'h40 one cycle after EXEC; other LEDs unchanged.
REQ-038 SET addr 3F, payload 8'h7F -> LEDs 0..7 become 7'h7F on 8 consecutive cycles; busy high 9 cycles after the latch.
REQ-039 READ addr 2 (LED2=7'h15), tx_rdy held 0 for 5 cycles then 1 -> o_tx_frame=16'h8215 stable throughout; tx_vld drops the cycle after the handshake.
REQ-040 READ addr 9 -> o_tx_frame=16'h09FF, err_cnt=1; an rx_dv during RSP -> ovr_cnt=1, frame dropped.
REQ-041 loc_req with simultaneous rx_dv -> no loc_gnt that cycle; loc_gnt is issued only after return to IDLE; 300 dropped frames -> ovr_cnt=255.
REQ-042 rst asserted mid-BCAST after 3 writes -> all LEDs 0, state IDLE, tx_vld 0 next cycle.

Source files
------------

// File: rtl/spi_cmd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl_pkg
// Shared constants for the SPI command controller: frame field widths,
// command codes, the broadcast address, FSM state codes and a saturating
// counter helper. Every file of the block imports this package.
// -----------------------------------------------------------------------------
package spi_cmd_ctrl_pkg;

    localparam int CMD_BITS           = 2;
    localparam int ADDR_BITS          = 6;
    localparam int PAYLOAD_BITS       = 8;
    localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int NUM_LEDS_DEFAULT   = 8;
    localparam int BRI_BITS_DEFAULT   = 7;

    localparam logic [CMD_BITS-1:0]  CMD_NOP      = 2'b00;
    localparam logic [CMD_BITS-1:0]  CMD_LED_SET  = 2'b01;
    localparam logic [CMD_BITS-1:0]  CMD_LED_READ = 2'b10;

    localparam logic [ADDR_BITS-1:0] ADDR_BCAST   = 6'h3F;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_BCAST = 2'd2;
    localparam logic [1:0] ST_RSP   = 2'd3;

    // Eight-bit event counter increment that sticks at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = value;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

    // True when an address selects an existing LED entry.
    function automatic logic addr_below(input logic [ADDR_BITS-1:0] addr,
                                        input int limit);
        addr_below = ({{(32-ADDR_BITS){1'b0}}, addr} < limit);
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_led_regfile.sv
// -----------------------------------------------------------------------------
// led_regfile
// Brightness register file with one write port and a flattened read bus.
// Ports:
//   clk_i      clock (rising edge)
//   rst_i      synchronous active-high reset, clears every entry
//   wr_en_i    write strobe
//   wr_addr_i  write index; indices >= NUM_LEDS are ignored
//   wr_data_i  brightness to write
//   rd_addr_i  random-access read index (unknown index reads 0)
//   rd_data_o  brightness at rd_addr_i
//   led_bri_o  all entries, LED k at [k*BRI_BITS +: BRI_BITS]
// -----------------------------------------------------------------------------
module led_regfile
    import spi_cmd_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = NUM_LEDS_DEFAULT,
    parameter int BRI_BITS = BRI_BITS_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en_i,
    input  logic [ADDR_BITS-1:0]         wr_addr_i,
    input  logic [BRI_BITS-1:0]          wr_data_i,
    input  logic [ADDR_BITS-1:0]         rd_addr_i,
    output logic [BRI_BITS-1:0]          rd_data_o,
    output logic [NUM_LEDS*BRI_BITS-1:0] led_bri_o
);

    logic [NUM_LEDS*BRI_BITS-1:0] bri_q;

    // Storage: clear on reset, otherwise update the single addressed entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bri_q <= {(NUM_LEDS*BRI_BITS){1'b0}};
        end else begin
            for (int k = 0; k < NUM_LEDS; k++) begin
                if (wr_en_i && (wr_addr_i == ADDR_BITS'(k))) begin
                    bri_q[k*BRI_BITS +: BRI_BITS] <= wr_data_i;
                end
            end
        end
    end

    // Read mux built as an OR of one-hot selected entries
    always_comb begin
        rd_data_o = {BRI_BITS{1'b0}};
        for (int k = 0; k < NUM_LEDS; k++) begin
            rd_data_o = rd_data_o |
                        ((rd_addr_i == ADDR_BITS'(k)) ? bri_q[k*BRI_BITS +: BRI_BITS]
                                                      : {BRI_BITS{1'b0}});
        end
    end

    assign led_bri_o = bri_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl
// Executes decoded SPI command frames against an LED brightness register
// file, returns read responses to the SPI slave and arbitrates a local writer
// that only gets the write port when the SPI side is idle.
// Ports:
//   sysclk, rst            clock / synchronous active-high reset
//   rx_dv, i_cmd, i_addr,
//   i_payload              decoded incoming frame, valid for one cycle
//   loc_req, loc_addr,
//   loc_bri, loc_gnt       local writer request / target / value / grant
//   tx_vld, tx_rdy,
//   o_tx_frame             response frame handshake to the SPI slave
//   o_led_bri              flattened brightness bus
//   busy                   command engine not idle
//   ovr_cnt, err_cnt       saturating dropped-frame / bad-command counters
// -----------------------------------------------------------------------------
module spi_cmd_ctrl
    import spi_cmd_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = NUM_LEDS_DEFAULT,
    parameter int BRI_BITS = BRI_BITS_DEFAULT
) (
    input  logic                          sysclk,
    input  logic                          rst,
    input  logic                          rx_dv,
    input  logic [CMD_BITS-1:0]           i_cmd,
    input  logic [ADDR_BITS-1:0]          i_addr,
    input  logic [PAYLOAD_BITS-1:0]       i_payload,
    input  logic                          loc_req,
    input  logic [ADDR_BITS-1:0]          loc_addr,
    input  logic [BRI_BITS-1:0]           loc_bri,
    output logic                          loc_gnt,
    output logic                          tx_vld,
    input  logic                          tx_rdy,
    output logic [MASTER_FRAME_WIDTH-1:0] o_tx_frame,
    output logic [NUM_LEDS*BRI_BITS-1:0]  o_led_bri,
    output logic                          busy,
    output logic [7:0]                    ovr_cnt,
    output logic [7:0]                    err_cnt
);

    logic [1:0]                    state_q,        state_d;
    logic [CMD_BITS-1:0]           hold_cmd_q,     hold_cmd_d;
    logic [ADDR_BITS-1:0]          hold_addr_q,    hold_addr_d;
    logic [PAYLOAD_BITS-1:0]       hold_payload_q, hold_payload_d;
    logic [ADDR_BITS-1:0]          bcast_idx_q,    bcast_idx_d;
    logic                          tx_vld_q,       tx_vld_d;
    logic [MASTER_FRAME_WIDTH-1:0] tx_frame_q,     tx_frame_d;
    logic [7:0]                    ovr_q,          ovr_d;
    logic [7:0]                    err_q,          err_d;

    logic                 hold_addr_ok_s;
    logic                 loc_addr_ok_s;
    logic                 bcast_last_s;
    logic                 loc_gnt_s;
    logic                 wr_en_s;
    logic [ADDR_BITS-1:0] wr_addr_s;
    logic [BRI_BITS-1:0]  wr_data_s;
    logic [BRI_BITS-1:0]  rd_data_s;

    assign hold_addr_ok_s = addr_below(hold_addr_q, NUM_LEDS);
    assign loc_addr_ok_s  = addr_below(loc_addr, NUM_LEDS);
    assign bcast_last_s   = (bcast_idx_q == ADDR_BITS'(NUM_LEDS - 1));
    // SPI traffic wins: a frame strobe in the same cycle blocks the grant.
    assign loc_gnt_s      = ~rst & (state_q == ST_IDLE) & ~rx_dv & loc_req;

    // Write-port mux: local writer in IDLE, command writes in EXEC/BCAST
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {ADDR_BITS{1'b0}};
        wr_data_s = {BRI_BITS{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (loc_gnt_s && loc_addr_ok_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = loc_addr;
                    wr_data_s = loc_bri;
                end else begin
                    wr_en_s   = 1'b0;
                end
            end
            ST_EXEC: begin
                if ((hold_cmd_q == CMD_LED_SET) && hold_addr_ok_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = hold_addr_q;
                    wr_data_s = hold_payload_q[BRI_BITS-1:0];
                end else begin
                    wr_en_s   = 1'b0;
                end
            end
            ST_BCAST: begin
                wr_en_s   = 1'b1;
                wr_addr_s = bcast_idx_q;
                wr_data_s = hold_payload_q[BRI_BITS-1:0];
            end
            default: begin
                wr_en_s   = 1'b0;
            end
        endcase
    end

    // Next-state logic for FSM, holding register, response frame and counters
    always_comb begin
        state_d        = state_q;
        hold_cmd_d     = hold_cmd_q;
        hold_addr_d    = hold_addr_q;
        hold_payload_d = hold_payload_q;
        bcast_idx_d    = bcast_idx_q;
        tx_vld_d       = tx_vld_q;
        tx_frame_d     = tx_frame_q;
        err_d          = err_q;

        // Any frame arriving while busy is dropped without touching the holder.
        if (rx_dv && (state_q != ST_IDLE)) begin
            ovr_d = sat_inc8(ovr_q);
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    hold_cmd_d     = i_cmd;
                    hold_addr_d    = i_addr;
                    hold_payload_d = i_payload;
                    state_d        = ST_EXEC;
                end else begin
                    state_d        = ST_IDLE;
                end
            end
            ST_EXEC: begin
                case (hold_cmd_q)
                    CMD_LED_SET: begin
                        if (hold_addr_ok_s) begin
                            state_d     = ST_IDLE;
                        end else if (hold_addr_q == ADDR_BCAST) begin
                            state_d     = ST_BCAST;
                            bcast_idx_d = {ADDR_BITS{1'b0}};
                        end else begin
                            err_d       = sat_inc8(err_q);
                            state_d     = ST_IDLE;
                        end
                    end
                    CMD_LED_READ: begin
                        tx_vld_d = 1'b1;
                        state_d  = ST_RSP;
                        if (hold_addr_ok_s) begin
                            tx_frame_d = {CMD_LED_READ, hold_addr_q, PAYLOAD_BITS'(rd_data_s)};
                        end else begin
                            tx_frame_d = {CMD_NOP, hold_addr_q, {PAYLOAD_BITS{1'b1}}};
                            err_d      = sat_inc8(err_q);
                        end
                    end
                    CMD_NOP: begin
                        state_d = ST_IDLE;
                    end
                    default: begin
                        err_d   = sat_inc8(err_q);
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_BCAST: begin
                if (bcast_last_s) begin
                    state_d     = ST_IDLE;
                end else begin
                    bcast_idx_d = bcast_idx_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                end
            end
            ST_RSP: begin
                if (tx_vld_q && tx_rdy) begin
                    tx_vld_d   = 1'b0;
                    tx_frame_d = {MASTER_FRAME_WIDTH{1'b0}};
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_RSP;
                end
            end
            default: begin
                tx_vld_d   = 1'b0;
                tx_frame_d = {MASTER_FRAME_WIDTH{1'b0}};
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            hold_cmd_q     <= {CMD_BITS{1'b0}};
            hold_addr_q    <= {ADDR_BITS{1'b0}};
            hold_payload_q <= {PAYLOAD_BITS{1'b0}};
            bcast_idx_q    <= {ADDR_BITS{1'b0}};
            tx_vld_q       <= 1'b0;
            tx_frame_q     <= {MASTER_FRAME_WIDTH{1'b0}};
            ovr_q          <= 8'h00;
            err_q          <= 8'h00;
        end else begin
            state_q        <= state_d;
            hold_cmd_q     <= hold_cmd_d;
            hold_addr_q    <= hold_addr_d;
            hold_payload_q <= hold_payload_d;
            bcast_idx_q    <= bcast_idx_d;
            tx_vld_q       <= tx_vld_d;
            tx_frame_q     <= tx_frame_d;
            ovr_q          <= ovr_d;
            err_q          <= err_d;
        end
    end

    led_regfile #(
        .NUM_LEDS (NUM_LEDS),
        .BRI_BITS (BRI_BITS)
    ) u_led_regfile (
        .clk_i     (sysclk),
        .rst_i     (rst),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wr_addr_s),
        .wr_data_i (wr_data_s),
        .rd_addr_i (hold_addr_q),
        .rd_data_o (rd_data_s),
        .led_bri_o (o_led_bri)
    );

    assign loc_gnt    = loc_gnt_s;
    assign busy       = (state_q != ST_IDLE);
    assign tx_vld     = tx_vld_q;
    assign o_tx_frame = tx_frame_q;
    assign ovr_cnt    = ovr_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_ctrl
// Directed stimulus against spi_cmd_ctrl. A schedule-based reference model
// (LED array, counters, pending-event queue) predicts all outputs; a compare
// process checks them every cycle, and the scenarios add hand-computed
// literal expectations.
// -----------------------------------------------------------------------------
module tb_spi_cmd_ctrl;

    localparam int N = 8;
    localparam int B = 7;

    logic          sysclk = 1'b0;
    logic          rst;
    logic          rx_dv;
    logic [1:0]    i_cmd;
    logic [5:0]    i_addr;
    logic [7:0]    i_payload;
    logic          loc_req;
    logic [5:0]    loc_addr;
    logic [B-1:0]  loc_bri;
    logic          loc_gnt;
    logic          tx_vld;
    logic          tx_rdy;
    logic [15:0]   o_tx_frame;
    logic [N*B-1:0] o_led_bri;
    logic          busy;
    logic [7:0]    ovr_cnt;
    logic [7:0]    err_cnt;

    spi_cmd_ctrl dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .rx_dv      (rx_dv),
        .i_cmd      (i_cmd),
        .i_addr     (i_addr),
        .i_payload  (i_payload),
        .loc_req    (loc_req),
        .loc_addr   (loc_addr),
        .loc_bri    (loc_bri),
        .loc_gnt    (loc_gnt),
        .tx_vld     (tx_vld),
        .tx_rdy     (tx_rdy),
        .o_tx_frame (o_tx_frame),
        .o_led_bri  (o_led_bri),
        .busy       (busy),
        .ovr_cnt    (ovr_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;   // edge number at which the effect lands
        int kind;  // 0 LED write, 1 error count, 2 response frame
        int idx;
        int val;
    } ev_t;

    int  cyc = 0;
    int  m_led[N];
    int  m_ovr = 0;
    int  m_err = 0;
    int  m_idle_at = 0;
    bit  m_wait_rsp = 1'b0;
    bit  m_tx_vld = 1'b0;
    int  m_tx_frame = 0;
    ev_t evq[$];

    function automatic bit m_busy();
        return (cyc < m_idle_at) || m_wait_rsp;
    endfunction

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    always @(posedge sysclk) begin : model_step
        bit  was_busy;
        bit  gnt;
        int  a;
        int  p;
        ev_t keep[$];
        was_busy = m_busy();
        gnt = !rst && !was_busy && !rx_dv && loc_req;
        cyc++;
        if (rst) begin
            foreach (m_led[k]) m_led[k] = 0;
            m_ovr = 0; m_err = 0; m_idle_at = 0; m_wait_rsp = 1'b0;
            m_tx_vld = 1'b0; m_tx_frame = 0;
            evq.delete();
        end else begin
            if (m_tx_vld && tx_rdy) begin
                m_tx_vld = 1'b0; m_tx_frame = 0; m_wait_rsp = 1'b0; m_idle_at = cyc;
            end
            keep = {};
            foreach (evq[i]) begin
                if (evq[i].due == cyc) begin
                    case (evq[i].kind)
                        0: m_led[evq[i].idx] = evq[i].val;
                        1: m_err = sat(m_err);
                        default: begin m_tx_vld = 1'b1; m_tx_frame = evq[i].val; end
                    endcase
                end else begin
                    keep.push_back(evq[i]);
                end
            end
            evq = keep;
            if (gnt && (int'(loc_addr) < N)) m_led[int'(loc_addr)] = int'(loc_bri);
            if (rx_dv) begin
                if (was_busy) begin
                    m_ovr = sat(m_ovr);
                end else begin
                    a = int'(i_addr);
                    p = int'(i_payload) & 'h7F;
                    case (i_cmd)
                        2'b01: begin
                            if (a < N) begin
                                evq.push_back('{cyc + 1, 0, a, p});
                                m_idle_at = cyc + 1;
                            end else if (a == 63) begin
                                for (int k = 0; k < N; k++) evq.push_back('{cyc + 2 + k, 0, k, p});
                                m_idle_at = cyc + 1 + N;
                            end else begin
                                evq.push_back('{cyc + 1, 1, 0, 0});
                                m_idle_at = cyc + 1;
                            end
                        end
                        2'b10: begin
                            m_wait_rsp = 1'b1;
                            if (a < N) begin
                                evq.push_back('{cyc + 1, 2, 0, (2 << 14) | (a << 8) | m_led[a]});
                            end else begin
                                evq.push_back('{cyc + 1, 2, 0, (a << 8) | 255});
                                evq.push_back('{cyc + 1, 1, 0, 0});
                            end
                        end
                        2'b00: m_idle_at = cyc + 1;
                        default: begin
                            evq.push_back('{cyc + 1, 1, 0, 0});
                            m_idle_at = cyc + 1;
                        end
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge sysclk) begin : compare
        logic [N*B-1:0] exp_bus;
        if (check_en) begin
            for (int k = 0; k < N; k++) exp_bus[k*B +: B] = B'(m_led[k]);
            chk("busy",     busy,       m_busy());
            chk("tx_vld",   tx_vld,     m_tx_vld);
            chk("tx_frame", o_tx_frame, 64'(m_tx_frame));
            chk("ovr_cnt",  ovr_cnt,    64'(m_ovr));
            chk("err_cnt",  err_cnt,    64'(m_err));
            chk("led_bus",  o_led_bri,  exp_bus);
            chk("loc_gnt",  loc_gnt,    !rst && !m_busy() && !rx_dv && loc_req);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] c, input logic [5:0] a, input logic [7:0] p);
        @(posedge sysclk); #2;
        rx_dv = 1'b1; i_cmd = c; i_addr = a; i_payload = p;
        @(posedge sysclk); #2;
        rx_dv = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(posedge sysclk); #2;
        end
        chk("wait_idle", busy, 1'b0);
    endtask

    task automatic handshake();
        tx_rdy = 1'b1;
        @(posedge sysclk); #2;
        tx_rdy = 1'b0;
    endtask

    initial begin
        int nb;
        int waited;
        rst = 1'b1; rx_dv = 1'b0; i_cmd = 2'b00; i_addr = 6'd0; i_payload = 8'd0;
        loc_req = 1'b0; loc_addr = 6'd0; loc_bri = 7'd0; tx_rdy = 1'b0;
        repeat (2) @(posedge sysclk);
        #2 rst = 1'b0;
        check_en = 1'b1;
        chk("rst_leds", o_led_bri, 56'd0);
        chk("rst_ovr",  ovr_cnt, 8'd0);
        chk("rst_err",  err_cnt, 8'd0);
        chk("rst_tx",   {tx_vld, o_tx_frame}, 17'd0);

        // single-LED writes
        send(2'b01, 6'd2, 8'h15); wait_idle();
        send(2'b01, 6'd3, 8'h40);
        chk("set3_before", o_led_bri[27:21], 7'h00);
        @(posedge sysclk); #2;
        chk("set3_after", o_led_bri[27:21], 7'h40);
        chk("set3_led2_kept", o_led_bri[20:14], 7'h15);
        send(2'b01, 6'd4, 8'hC1); wait_idle();
        chk("set4_msb_dropped", o_led_bri[34:28], 7'h41);

        // broadcast
        send(2'b01, 6'h3F, 8'h7F);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            nb++;
            @(posedge sysclk); #2;
        end
        chk("bcast_busy_cycles", nb, 9);
        chk("bcast_all", o_led_bri, {8{7'h7F}});

        // read with delayed handshake
        send(2'b01, 6'd2, 8'h15); wait_idle();
        send(2'b10, 6'd2, 8'h00);
        @(posedge sysclk); #2;
        chk("rd2_vld", tx_vld, 1'b1);
        chk("rd2_frame", o_tx_frame, 16'h8215);
        repeat (4) begin
            @(posedge sysclk); #2;
            chk("rd2_hold", o_tx_frame, 16'h8215);
        end
        handshake();
        chk("rd2_vld_drop", tx_vld, 1'b0);
        chk("rd2_frame_zero", o_tx_frame, 16'h0000);

        // invalid read, frame dropped during RSP
        send(2'b10, 6'd9, 8'h00);
        @(posedge sysclk); #2;
        chk("rd9_frame", o_tx_frame, 16'h09FF);
        chk("rd9_err", err_cnt, 8'd1);
        send(2'b01, 6'd0, 8'h11);
        chk("drop_ovr", ovr_cnt, 8'd1);
        @(posedge sysclk); #2;
        chk("drop_led0_kept", o_led_bri[6:0], 7'h7F);
        handshake(); wait_idle();

        // local writer versus SPI priority
        @(posedge sysclk); #2;
        rx_dv = 1'b1; i_cmd = 2'b01; i_addr = 6'd1; i_payload = 8'h33;
        loc_req = 1'b1; loc_addr = 6'd5; loc_bri = 7'h2A;
        #1 chk("gnt_blocked", loc_gnt, 1'b0);
        @(posedge sysclk); #2;
        rx_dv = 1'b0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            if (loc_gnt) break;
            waited++;
            @(posedge sysclk); #2;
        end
        chk("gnt_wait", waited, 1);
        chk("gnt_seen", loc_gnt, 1'b1);
        @(posedge sysclk); #2;
        loc_req = 1'b0;
        chk("loc_led5", o_led_bri[41:35], 7'h2A);
        chk("spi_led1", o_led_bri[13:7], 7'h33);
        loc_req = 1'b1; loc_addr = 6'd12; loc_bri = 7'h7F;
        for (int i = 0; i < 20; i++) begin
            if (loc_gnt) break;
            @(posedge sysclk); #2;
        end
        chk("gnt_bad_addr", loc_gnt, 1'b1);
        @(posedge sysclk); #2;
        loc_req = 1'b0;
        chk("gnt_bad_no_err", err_cnt, 8'd1);

        // invalid command and invalid SET address
        send(2'b11, 6'd0, 8'h00); wait_idle();
        send(2'b01, 6'd20, 8'h01); wait_idle();
        chk("err_three", err_cnt, 8'd3);

        // flood of dropped frames during a parked response
        send(2'b10, 6'd0, 8'h00);
        rx_dv = 1'b1; i_cmd = 2'b00;
        repeat (300) @(posedge sysclk);
        #2 rx_dv = 1'b0;
        chk("ovr_saturated", ovr_cnt, 8'd255);
        chk("rd0_frame", o_tx_frame, 16'h807F);
        handshake(); wait_idle();

        // reset in the middle of a broadcast
        send(2'b01, 6'h3F, 8'h55);
        repeat (4) @(posedge sysclk);
        #2;
        chk("bcast_partial", o_led_bri[20:0], {3{7'h55}});
        chk("bcast_led3_old", o_led_bri[27:21], 7'h7F);
        chk("bcast_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge sysclk); #2;
        rst = 1'b0;
        chk("abort_leds", o_led_bri, 56'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_tx", tx_vld, 1'b0);
        chk("abort_ovr", ovr_cnt, 8'd0);
        repeat (3) @(posedge sysclk);
        #2;
        chk("abort_stays_clear", o_led_bri, 56'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
